ms_bus_arbiter: RTL
===================

// Module: ms_bus_arbiter
// PURPOSE
//  Round-robin arbiter that shares one ms-style slave port (addr/data out, sready back) between
//  NREQ master requesters. Sits between several master engines and a single slave register block.
//  Grants one owner at a time and forwards its addr/data while the slave accepts beats.
//  Bounds each ownership to MAX_BURST accepted beats so that no requester is starved.
// PARAMETERS
//  NREQ       4  number of requesters (2..8)
//  AW         2  address width
//  DW         8  data width
//  MAX_BURST  4  accepted beats per grant before forced release (1..15)
// PORTS
//  clk        in   1        clock; all logic is on posedge
//  rst        in   1        synchronous reset, active-high
//  req        in   NREQ     per-requester request; held while the requester has beats to send
//  req_addr   in   NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
//  req_data   in   NREQ*DW  packed data; requester i uses bits [i*DW +: DW]
//  gnt        out  NREQ     one-hot registered grant (all zero when idle)
//  beat_ack   out  NREQ     one-hot pulse: requester i's beat was accepted this cycle
//  s_valid    out  1        beat valid toward slave
//  s_addr     out  AW       address toward slave
//  s_data     out  DW       data toward slave
//  s_ready    in   1        slave ready (sready); a beat is accepted when s_valid & s_ready
//  owner      out  $clog2(NREQ)  index of the current or last owner
// BEHAVIOUR
//  Reset: gnt=0, beat_ack=0, s_valid=0, s_addr=0, s_data=0, owner=0, beat_cnt=0, state=IDLE.
//   The round-robin pointer is reset to NREQ-1, so requester 0 wins first.
//  States:
//   IDLE: if |req, pick the first set req scanning from ptr+1 upward, wrapping mod NREQ.
//    Register gnt and owner; go to OWN.
//    Latency: req sampled high in cycle n gives gnt high in cycle n+1.
//   OWN:
//    s_valid = req[owner]; s_addr/s_data = owner's slice. These are a combinational mux on the
//     registered owner, forced to 0 when s_valid is 0.
//    beat_ack[owner] = s_valid & s_ready.
//    Each accepted beat increments beat_cnt (4-bit, saturating at MAX_BURST).
//    Release, back to IDLE with gnt=0 and ptr=owner next cycle, when either:
//     (a) req[owner] is sampled low; or
//     (b) an accept occurs with beat_cnt == MAX_BURST-1.
//    On release, beat_cnt clears.
//  Gap: exactly one idle cycle (gnt=0) between any two grants, including a re-grant to the same
//   requester.
//  Stall: s_ready low holds state. gnt, beat_cnt, s_addr and s_data are stable; no beat_ack.
//  Simultaneous events: a req drop in the same cycle as the final-beat accept counts as one
//   release. Requests from non-owners are ignored until IDLE.
//  Non-owner inputs never reach s_addr/s_data.
//  Reset mid-burst: all state returns to reset values in the next cycle. The partial burst is
//   abandoned with no further beat_ack.
// CONFIGURATION
//  MS_ARB_LOCK_EN defined:
//   Adds input req_lock [NREQ]. While req_lock[owner] is high, release (b) is suppressed, so the
//    owner keeps the grant until its req drops.
//   beat_cnt still saturates at MAX_BURST.
//  MS_ARB_LOCK_EN undefined:
//   req_lock does not exist; the MAX_BURST limit always applies.
// TESTING
//  1. rst=1 for 2 cycles with req=4'b1111
//     -> gnt=0, s_valid=0, s_addr=0, s_data=0 throughout; first grant after rst drops is gnt=4'b0001.
//  2. Only req[2] high for 10 cycles, s_ready=1, MAX_BURST=4
//     -> 4 beat_ack[2] pulses, 1 idle cycle, regrant, 4 more pulses.
//  3. req=4'b1011 held, s_ready=1
//     -> grant order 0,1,3,0 with 4 beats each and a 1-cycle gap between grants.
//  4. Owner 1 sending addr=2'd3, data=8'hA5 with s_ready low for 3 cycles
//     -> s_addr/s_data stable, beat_ack=0, gnt unchanged; accepted on the first s_ready=1 cycle.
//  5. Owner 0 drops req after 2 beats while req[3] is high
//     -> next cycle gnt=0; the cycle after, gnt=4'b1000.
//  6. rst pulsed mid-burst (beat 2), then MS_ARB_LOCK_EN build with req_lock[0]=1
//     -> reset values restored; after reset, requester 0 keeps the grant for more than 4 beats
//        until req[0] drops.

Source files
------------

// File: rtl/ms_bus_arbiter.sv
// ms_bus_arbiter: round-robin arbiter that shares one ms-style slave port
// (valid/addr/data out, ready back) between NREQ master requesters.
//
// Each grant lasts until the owner drops its request or until MAX_BURST
// beats have been accepted. Every grant is followed by one idle cycle.
//
// Optional feature macro: MS_ARB_LOCK_EN
//   When defined, the input req_lock is added. While req_lock[owner] is high,
//   the owner is not released at the burst limit and keeps the grant until
//   its req drops.
//
// Handshake: the slave side uses strict valid/ready semantics. A beat
// transfers on a rising clock edge where s_valid and s_ready are both high.
// s_valid, s_addr and s_data depend only on registered state and the current
// owner's inputs, never on s_ready. While a beat is stalled (s_ready low) they
// stay stable as long as the owner keeps its request and payload stable.
// beat_ack reports the transfer back to the owning requester in the same cycle.

module ms_bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 2,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  localparam int OW       = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
`ifdef MS_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      beat_ack,
  output logic                 s_valid,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_data,
  input  logic                 s_ready,
  output logic [OW-1:0]        owner,
  output logic                 state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  // Registered state
  state_t          state;
  logic [NREQ-1:0] gnt_r;
  logic [OW-1:0]   owner_r;
  logic [OW-1:0]   ptr;
  logic [3:0]      beat_cnt;

  // Next-state values
  state_t          state_n;
  logic [NREQ-1:0] gnt_n;
  logic [OW-1:0]   owner_n;
  logic [OW-1:0]   ptr_n;
  logic [3:0]      beat_cnt_n;

  // Round-robin pick
  logic            pick_vld;
  logic [OW-1:0]   pick_idx;
  logic [OW-1:0]   cand;

  // Owner-side view of the requester inputs
  logic            req_own;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NREQ-1:0] own_onehot;
  logic            lock_own;
  logic            in_own;
  logic            accept;
  logic            last_beat;
  logic            release_now;

  // Scan from ptr+1 upward, wrapping, and take the first active request.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = OW'((int'(ptr) + i) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Select the current owner's request and payload. Only the owner's slice can
  // reach the slave port.
  always_comb begin
    req_own  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_r == OW'(i)) begin
        req_own  = req[i];
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign own_onehot = ONE_HOT0 << owner_r;

`ifdef MS_ARB_LOCK_EN
  assign lock_own = |(req_lock & own_onehot);
`else
  assign lock_own = 1'b0;
`endif

  // Slave-side outputs. A cycle with rst high drives nothing so that an
  // abandoned burst produces no further acknowledge.
  always_comb begin
    in_own      = (state == OWN) && !rst;
    s_valid     = in_own && req_own;
    s_addr      = s_valid ? sel_addr : '0;
    s_data      = s_valid ? sel_data : '0;
    accept      = s_valid && s_ready;
    beat_ack    = accept ? own_onehot : '0;
    last_beat   = accept && (beat_cnt == 4'(MAX_BURST - 1)) && !lock_own;
    // A request drop and a final-beat accept in the same cycle give one release.
    release_now = (state == OWN) && (!req_own || last_beat);
  end

  // FSM next state: grant in IDLE, count beats and release in OWN.
  always_comb begin
    state_n    = state;
    gnt_n      = gnt_r;
    owner_n    = owner_r;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_n = OWN;
          gnt_n   = ONE_HOT0 << pick_idx;
          owner_n = pick_idx;
        end
      end
      OWN: begin
        if (accept && (beat_cnt < 4'(MAX_BURST))) begin
          beat_cnt_n = beat_cnt + 4'd1;
        end
        if (release_now) begin
          state_n    = IDLE;
          gnt_n      = '0;
          ptr_n      = owner_r;
          beat_cnt_n = '0;
        end
      end
      default: begin
        state_n    = IDLE;
        gnt_n      = '0;
        beat_cnt_n = '0;
      end
    endcase
  end

  // State register. The pointer resets to the last requester so that
  // requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_r    <= '0;
      owner_r  <= '0;
      ptr      <= OW'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt_r    <= gnt_n;
      owner_r  <= owner_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  assign gnt       = gnt_r;
  assign owner     = owner_r;
  assign state_dbg = (state == OWN);

endmodule
